// File: rtl/merge_node_2to1.sv
// 2-to-1 merge node of the merger tree: merges two descending-sorted,
// zero-key-terminated record streams into one, ending with a single terminator.
module merge_node_2to1 #(
    parameter int P_WIDTH     = 128,
    parameter int P_KEY_WIDTH = 32,
    parameter int P_CNT_WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [P_WIDTH-1:0]     i_a_data,
    input  logic                   i_a_empty,
    output logic                   o_a_deq,
    input  logic [P_WIDTH-1:0]     i_b_data,
    input  logic                   i_b_empty,
    output logic                   o_b_deq,
    output logic [P_WIDTH-1:0]     o_data,
    output logic                   o_enq,
    input  logic                   i_full,
    output logic                   o_stream_done,
    output logic [P_CNT_WIDTH-1:0] o_last_count
);

    typedef enum logic [1:0] {
        MERGE,
        DRAIN_A,
        DRAIN_B
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [P_CNT_WIDTH-1:0] count;

    logic [P_KEY_WIDTH-1:0] key_a;
    logic [P_KEY_WIDTH-1:0] key_b;
    logic                   emit;
    logic                   sel_b;
    logic                   term;

    assign key_a = i_a_data[P_WIDTH-1 -: P_KEY_WIDTH];
    assign key_b = i_b_data[P_WIDTH-1 -: P_KEY_WIDTH];

    // Next-state, pop and emit selection from heads, empties and backpressure
    always_comb begin
        state_next = state;
        o_a_deq    = 1'b0;
        o_b_deq    = 1'b0;
        emit       = 1'b0;
        sel_b      = 1'b0;
        term       = 1'b0;
        case (state)
            MERGE: begin
                if (!i_a_empty && !i_b_empty && !i_full) begin
                    emit = 1'b1;
                    if (key_a != '0 && key_b != '0) begin
                        // Tie goes to A
                        if (key_a >= key_b) begin
                            o_a_deq = 1'b1;
                        end else begin
                            o_b_deq = 1'b1;
                            sel_b   = 1'b1;
                        end
                    end else if (key_a == '0 && key_b != '0) begin
                        // A's terminator is swallowed here; B's ends the merged stream
                        o_a_deq    = 1'b1;
                        o_b_deq    = 1'b1;
                        sel_b      = 1'b1;
                        state_next = DRAIN_B;
                    end else if (key_a != '0 && key_b == '0) begin
                        o_a_deq    = 1'b1;
                        o_b_deq    = 1'b1;
                        state_next = DRAIN_A;
                    end else begin
                        o_a_deq = 1'b1;
                        o_b_deq = 1'b1;
                        term    = 1'b1;
                    end
                end
            end
            DRAIN_A: begin
                if (!i_a_empty && !i_full) begin
                    o_a_deq = 1'b1;
                    emit    = 1'b1;
                    if (key_a == '0) begin
                        term       = 1'b1;
                        state_next = MERGE;
                    end
                end
            end
            DRAIN_B: begin
                if (!i_b_empty && !i_full) begin
                    o_b_deq = 1'b1;
                    emit    = 1'b1;
                    sel_b   = 1'b1;
                    if (key_b == '0) begin
                        term       = 1'b1;
                        state_next = MERGE;
                    end
                end
            end
            default: state_next = MERGE;
        endcase
    end

    // State register, registered output record and per-stream record counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= MERGE;
            o_enq         <= 1'b0;
            o_data        <= '0;
            o_stream_done <= 1'b0;
            o_last_count  <= '0;
            count         <= '0;
        end else begin
            state         <= state_next;
            o_enq         <= emit;
            o_stream_done <= term;
            if (emit) begin
                o_data <= sel_b ? i_b_data : i_a_data;
            end
            if (term) begin
                o_last_count <= count;
                count        <= '0;
            end else if (emit) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_merge_node_2to1.sv
// Randomised and directed checks of merge_node_2to1 against a queue-based
// stable-merge reference model.
module tb_merge_node_2to1;

    localparam int W  = 128;
    localparam int KW = 32;
    localparam int CW = 32;

    logic          clk;
    logic          rst;
    logic [W-1:0]  a_data;
    logic          a_empty;
    logic          a_deq;
    logic [W-1:0]  b_data;
    logic          b_empty;
    logic          b_deq;
    logic [W-1:0]  out_data;
    logic          enq;
    logic          full;
    logic          done;
    logic [CW-1:0] last_count;

    merge_node_2to1 #(
        .P_WIDTH     (W),
        .P_KEY_WIDTH (KW),
        .P_CNT_WIDTH (CW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_a_data      (a_data),
        .i_a_empty     (a_empty),
        .o_a_deq       (a_deq),
        .i_b_data      (b_data),
        .i_b_empty     (b_empty),
        .o_b_deq       (b_deq),
        .o_data        (out_data),
        .o_enq         (enq),
        .i_full        (full),
        .o_stream_done (done),
        .o_last_count  (last_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input FIFO contents, expected output records and expected per-stream counts
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic [W-1:0] exp_q[$];
    int unsigned  exp_cnt[$];
    int unsigned  ka_q[$];
    int unsigned  kb_q[$];

    logic [W-1:0] last_out;
    logic         fa;
    logic         fb;
    bit           rand_mode;
    bit           force_full;
    bit           force_hide_a;
    bit           force_hide_b;
    bit           expect_fire;
    int           errors;
    int           checks;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [KW-1:0] key_of(input logic [W-1:0] r);
        return r[W-1 -: KW];
    endfunction

    function automatic logic [W-1:0] make_rec(input int unsigned key);
        logic [W-1:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        r[W-1 -: KW] = key;
        return r;
    endfunction

    // Loads one stream pair (keys from ka_q/kb_q, terminators appended) and
    // computes the expected merged stream: stable descending merge with A first
    // on equal keys, closed by the terminator of whichever stream supplied the
    // last non-terminator (A's when both are empty).
    task automatic gen_pair();
        logic [W-1:0] ra[$];
        logic [W-1:0] rb[$];
        logic [W-1:0] ta;
        logic [W-1:0] tb;
        int           i;
        int           j;
        bit           last_b;
        foreach (ka_q[n]) ra.push_back(make_rec(ka_q[n]));
        foreach (kb_q[n]) rb.push_back(make_rec(kb_q[n]));
        ta = make_rec(0);
        tb = make_rec(0);
        foreach (ra[n]) qa.push_back(ra[n]);
        foreach (rb[n]) qb.push_back(rb[n]);
        qa.push_back(ta);
        qb.push_back(tb);
        i = 0;
        j = 0;
        last_b = 1'b0;
        while (i < ra.size() || j < rb.size()) begin
            if (j >= rb.size() || (i < ra.size() && key_of(ra[i]) >= key_of(rb[j]))) begin
                exp_q.push_back(ra[i]);
                i++;
                last_b = 1'b0;
            end else begin
                exp_q.push_back(rb[j]);
                j++;
                last_b = 1'b1;
            end
        end
        exp_q.push_back(last_b ? tb : ta);
        exp_cnt.push_back(ra.size() + rb.size());
    endtask

    task automatic rand_keys(output int unsigned q[$]);
        int k;
        int n;
        q.delete();
        n = $urandom_range(0, 5);
        k = $urandom_range(4, 30);
        for (int i = 0; i < n; i++) begin
            k = k - int'($urandom_range(0, 3));
            if (k < 1) k = 1;
            q.push_back(k);
        end
    endtask

    // One clock cycle: starts and ends just after a falling edge
    task automatic step();
        bit ha;
        bit hb;
        full = force_full | (rand_mode && $urandom_range(0, 3) == 0);
        ha   = force_hide_a | (rand_mode && $urandom_range(0, 4) == 0);
        hb   = force_hide_b | (rand_mode && $urandom_range(0, 4) == 0);
        a_empty = (qa.size() == 0) || ha;
        b_empty = (qb.size() == 0) || hb;
        a_data  = (qa.size() != 0) ? qa[0] : {4{$urandom()}};
        b_data  = (qb.size() != 0) ? qb[0] : {4{$urandom()}};
        #1;
        fa = a_deq;
        fb = b_deq;
        check_eq("deq_a_legal", W'(fa & (a_empty | full)), '0);
        check_eq("deq_b_legal", W'(fb & (b_empty | full)), '0);
        if (expect_fire && (qa.size() + qb.size() > 0)) begin
            check_eq("throughput", W'(fa | fb), W'(1));
        end
        @(posedge clk);
        #1;
        if (fa && qa.size() != 0) void'(qa.pop_front());
        if (fb && qb.size() != 0) void'(qb.pop_front());
        @(negedge clk);
        check_eq("enq_latency", W'(enq), W'(fa | fb));
        if (enq) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out", out_data, '0);
                check_eq("unexpected_enq", W'(enq), '0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check_eq("data", out_data, e);
                check_eq("stream_done", W'(done), W'(key_of(e) == '0));
                if (key_of(e) == '0) begin
                    int unsigned c;
                    c = (exp_cnt.size() != 0) ? exp_cnt.pop_front() : 0;
                    check_eq("last_count", W'(last_count), W'(c));
                end
                last_out = e;
            end
        end else begin
            check_eq("data_hold", out_data, last_out);
            check_eq("done_idle", W'(done), '0);
        end
    endtask

    task automatic run_drain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            check_eq("timeout_pending", W'(exp_q.size()), '0);
            exp_q.delete();
            exp_cnt.delete();
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rand_mode = 1'b0;
        force_full = 1'b0;
        force_hide_a = 1'b0;
        force_hide_b = 1'b0;
        expect_fire = 1'b0;
        rst = 1'b1;
        full = 1'b0;
        a_empty = 1'b1;
        b_empty = 1'b1;
        a_data = '0;
        b_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_enq", W'(enq), '0);
        check_eq("rst_data", out_data, '0);
        check_eq("rst_done", W'(done), '0);
        check_eq("rst_last_count", W'(last_count), '0);
        last_out = '0;
        rst = 1'b0;

        // Basic merge at full rate
        expect_fire = 1'b1;
        ka_q = '{9, 5};
        kb_q = '{7, 3};
        gen_pair();
        run_drain(20);

        // Tie: A's record first
        ka_q = '{4};
        kb_q = '{4};
        gen_pair();
        run_drain(20);

        // B ends first; B's next stream waits until MERGE is re-entered
        ka_q = '{8, 6, 2};
        kb_q = '{};
        gen_pair();
        ka_q = '{3};
        kb_q = '{5};
        gen_pair();
        step();
        check_eq("t3_pop_both", W'({fa, fb}), W'(2'b11));
        run_drain(30);

        // Backpressure window mid-stream
        ka_q = '{20, 15, 10, 5};
        kb_q = '{18, 12, 6};
        gen_pair();
        step();
        step();
        force_full = 1'b1;
        expect_fire = 1'b0;
        repeat (10) step();
        force_full = 1'b0;
        expect_fire = 1'b1;
        run_drain(30);

        // MERGE stalls while A looks empty
        ka_q = '{5};
        kb_q = '{7};
        gen_pair();
        force_hide_a = 1'b1;
        expect_fire = 1'b0;
        repeat (3) begin
            step();
            check_eq("stall_no_pop", W'(fa | fb), '0);
        end
        force_hide_a = 1'b0;
        expect_fire = 1'b1;
        run_drain(20);

        // DRAIN_A keeps going while B is empty
        ka_q = '{9, 8, 7, 6};
        kb_q = '{};
        gen_pair();
        step();
        force_hide_b = 1'b1;
        run_drain(20);
        force_hide_b = 1'b0;

        // Randomised streams, random backpressure and empties
        expect_fire = 1'b0;
        rand_mode = 1'b1;
        for (int p = 0; p < 40; p++) begin
            rand_keys(ka_q);
            rand_keys(kb_q);
            gen_pair();
        end
        run_drain(4000);
        rand_mode = 1'b0;

        // Reset while in DRAIN_B, then a fresh pair
        expect_fire = 1'b1;
        ka_q = '{};
        kb_q = '{7, 6, 5};
        gen_pair();
        step();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        qa.delete();
        qb.delete();
        exp_q.delete();
        exp_cnt.delete();
        a_empty = 1'b1;
        b_empty = 1'b1;
        @(negedge clk);
        check_eq("rst2_enq", W'(enq), '0);
        check_eq("rst2_last_count", W'(last_count), '0);
        check_eq("rst2_done", W'(done), '0);
        check_eq("rst2_data", out_data, '0);
        last_out = '0;
        ka_q = '{9, 5};
        kb_q = '{7, 3};
        gen_pair();
        run_drain(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
